// File: rtl/darkroom_pkg.sv
// Shared constants and FSM encoding for the lighthouse frame-to-SPI scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package darkroom_pkg;

    localparam int FRAME_WIDTH       = 256;
    localparam int BYTES_PER_FRAME   = 32;
    localparam int SENSORS_PER_FRAME = 8;
    localparam int MAX_FRAMES        = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_LATCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_WAIT_REQ = 3'd5,
        ST_WAIT_END = 3'd6,
        ST_GAP      = 3'd7
    } state_t;

endpackage

// File: rtl/darkroom_rr_arbiter.sv
// Round-robin pick: first requesting frame strictly after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller samples the grant when it is ready to use it.
// Ports: req_i (pending vector), ptr_i (last served index),
//        grant_o (one-hot), idx_o (binary index), any_o (some request present).
module darkroom_rr_arbiter #(
    parameter int N = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   ptr_i,
    output logic [N-1:0] grant_o,
    output logic [3:0]   idx_o,
    output logic         any_o
);

    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        // Scan ptr+1 .. ptr+N so the last-served frame gets lowest priority.
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = 4'(j);
            end
        end
    end

endmodule

// File: rtl/darkroom_spi_scheduler.sv
// Streams 256-bit sensor frames, picked round-robin from pending flags, into a byte SPI master.
// Latency: pending set -> wren_o high in 3 clocks from IDLE; then one byte per wr_ack_i.
// Backpressure: holds wren_o/byte_o until wr_ack_i, waits for di_req_i between bytes.
// Ports: sync_i/trigger_i mark frames pending; frame_sel_o/frame_i fetch frame data;
//        byte_o/wren_o/di_req_i/wr_ack_i/ss_n_i talk to the SPI master;
//        busy_o, frames_sent_o, overrun_o, timeout_o report status (clear_i clears stickies).
module darkroom_spi_scheduler
    import darkroom_pkg::*;
#(
    parameter int NUMBER_OF_SENSORS = 8,
    parameter int GAP_CYCLES        = 1023,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUMBER_OF_SENSORS-1:0] sync_i,
    input  logic                         trigger_i,
    input  logic                         clear_i,
    output logic [3:0]                   frame_sel_o,
    input  logic [255:0]                 frame_i,
    output logic [7:0]                   byte_o,
    output logic                         wren_o,
    input  logic                         di_req_i,
    input  logic                         wr_ack_i,
    input  logic                         ss_n_i,
    output logic                         busy_o,
    output logic [15:0]                  frames_sent_o,
    output logic                         overrun_o,
    output logic                         timeout_o
);

    localparam int NUM_FRAMES = (NUMBER_OF_SENSORS + SENSORS_PER_FRAME - 1) / SENSORS_PER_FRAME;
    localparam int SYNC_PAD   = NUM_FRAMES * SENSORS_PER_FRAME;

    state_t                 state_q, state_d;
    logic [NUM_FRAMES-1:0]  pending_q, pending_d;
    logic [NUM_FRAMES-1:0]  sel_oh_q, sel_oh_d;
    logic [NUM_FRAMES-1:0]  sync_hit, set_vec, clr_vec, grant;
    logic [3:0]             sel_q, sel_d, rr_q, rr_d, grant_idx;
    logic                   grant_any;
    logic [FRAME_WIDTH-1:0] shadow_q, shadow_d;
    logic [4:0]             k_q, k_d;
    logic [15:0]            cnt_q, cnt_d, sent_q, sent_d;
    logic                   ss_prev_q;
    logic                   overrun_q, overrun_d, timeout_q, timeout_d;
    logic [SYNC_PAD-1:0]    sync_pad;

    // Partial last frame: unused sensor slots read as zero.
    assign sync_pad = SYNC_PAD'(sync_i);

    // Pending bookkeeping: set wins over the LATCH-cycle clear.
    always_comb begin
        sync_hit = '0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            sync_hit[f] = |sync_pad[f*SENSORS_PER_FRAME +: SENSORS_PER_FRAME];
        end
        set_vec   = sync_hit | {NUM_FRAMES{trigger_i}};
        clr_vec   = (state_q == ST_LATCH) ? sel_oh_q : '0;
        pending_d = (pending_q & ~clr_vec) | set_vec;
        // A frame being latched this cycle is not an overrun: the new sync re-arms it.
        overrun_d = (overrun_q & ~clear_i) | (|(sync_hit & pending_q & ~clr_vec));
    end

    darkroom_rr_arbiter #(.N(NUM_FRAMES)) u_arb (
        .req_i   (pending_q),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel_oh_d  = sel_oh_q;
        rr_d      = rr_q;
        shadow_d  = shadow_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        sent_d    = sent_q;
        timeout_d = timeout_q & ~clear_i;
        wren_o    = 1'b0;
        byte_o    = 8'h00;
        busy_o    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    sel_d    = grant_idx;
                    sel_oh_d = grant;
                    state_d  = ST_SELECT;
                end
            end
            // frame_sel_o changed on entry; give the owner's mux a cycle to settle.
            ST_SELECT: state_d = ST_LATCH;
            ST_LATCH: begin
                shadow_d = frame_i;
                rr_d     = sel_q;
                k_d      = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                wren_o  = 1'b1;
                byte_o  = shadow_q[k_q*8 +: 8];
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                wren_o = 1'b1;
                byte_o = shadow_q[k_q*8 +: 8];
                if (wr_ack_i) begin
                    if (k_q == 5'(BYTES_PER_FRAME - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_END;
                    end else begin
                        k_d     = k_q + 5'd1;
                        state_d = ST_WAIT_REQ;
                    end
                end
            end
            ST_WAIT_REQ: begin
                if (di_req_i) state_d = ST_SEND;
            end
            ST_WAIT_END: begin
                if (!ss_prev_q && ss_n_i) begin
                    sent_d  = sent_q + 16'd1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                              cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            sel_q     <= '0;
            sel_oh_q  <= '0;
            rr_q      <= '0;
            shadow_q  <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            sent_q    <= '0;
            ss_prev_q <= 1'b1;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            sel_oh_q  <= sel_oh_d;
            rr_q      <= rr_d;
            shadow_q  <= shadow_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            sent_q    <= sent_d;
            ss_prev_q <= ss_n_i;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign frame_sel_o   = sel_q;
    assign frames_sent_o = sent_q;
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_darkroom_spi_scheduler.sv
// Bench for darkroom_spi_scheduler: 24 sensors (3 frames), short gap and timeout.
// Latency: n/a.
// Backpressure: an SPI master model with random ack/request delays.
module tb_darkroom_spi_scheduler;

    localparam int NS  = 24;
    localparam int NF  = 3;
    localparam int GAP = 20;
    localparam int TO  = 100;

    logic          clock, reset_n;
    logic [NS-1:0] sync_i;
    logic          trigger_i, clear_i;
    logic [3:0]    frame_sel_o;
    logic [255:0]  frame_i;
    logic [7:0]    byte_o;
    logic          wren_o, di_req_i, wr_ack_i, ss_n_i, busy_o;
    logic [15:0]   frames_sent_o;
    logic          overrun_o, timeout_o;

    darkroom_spi_scheduler #(
        .NUMBER_OF_SENSORS(NS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sync_i(sync_i), .trigger_i(trigger_i),
        .clear_i(clear_i), .frame_sel_o(frame_sel_o), .frame_i(frame_i),
        .byte_o(byte_o), .wren_o(wren_o), .di_req_i(di_req_i), .wr_ack_i(wr_ack_i),
        .ss_n_i(ss_n_i), .busy_o(busy_o), .frames_sent_o(frames_sent_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    logic [255:0] mem [NF];
    always_comb frame_i = (frame_sel_o < 4'(NF)) ? mem[frame_sel_o[1:0]] : '0;

    int n_tests = 0, n_fail = 0;
    int exp_sent = 0, model_ptr = 0, mon_idx = 0;
    logic [7:0] exp_bytes[$];
    int         exp_frame[$];
    bit hold_ss = 0;
    int spi_st = 0, spi_dly = 0, spi_nbytes = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // SPI master model: acks 1..3 cycles after seeing wren, requests the next byte
    // 0..3 cycles later, raises ss_n a few cycles after the last byte.
    initial begin
        ss_n_i = 1; wr_ack_i = 0; di_req_i = 0;
        forever begin
            @(negedge clock);
            wr_ack_i = 0;
            di_req_i = 0;
            if (!reset_n) begin
                spi_st = 0; spi_nbytes = 0; ss_n_i = 1;
            end else if (spi_st == 0) begin
                if (wren_o) begin
                    ss_n_i = 0; spi_dly = $urandom_range(0, 2); spi_st = 1;
                end
            end else if (spi_st == 1) begin
                if (spi_dly == 0) begin
                    wr_ack_i = 1;
                    spi_nbytes++;
                    if (spi_nbytes == 32) begin
                        spi_nbytes = 0; spi_st = 3; spi_dly = $urandom_range(0, 2);
                    end else begin
                        spi_st = 2; spi_dly = $urandom_range(0, 3);
                    end
                end else spi_dly--;
            end else if (spi_st == 2) begin
                if (spi_dly == 0) begin di_req_i = 1; spi_st = 0; end
                else spi_dly--;
            end else if (spi_st == 3 && !hold_ss) begin
                if (spi_dly == 0) begin ss_n_i = 1; spi_st = 0; end
                else spi_dly--;
            end
        end
    end

    // Monitor: every accepted byte is compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && wren_o && wr_ack_i) begin
                if (mon_idx == 0 && exp_frame.size() > 0)
                    check("frame_sel", frame_sel_o, exp_frame.pop_front());
                if (exp_bytes.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", byte_o);
                end else begin
                    check("spi_byte", byte_o, exp_bytes.pop_front());
                end
                mon_idx = (mon_idx + 1) % 32;
            end
        end
    end

    task automatic push_frame(input int f);
        exp_frame.push_back(f);
        for (int b = 0; b < 32; b++) exp_bytes.push_back(mem[f][8*b +: 8]);
    endtask

    // Reference: frames pending together are served in cyclic order after the last served one.
    task automatic issue(input logic [NS-1:0] sv, input logic trig, input bit count);
        logic [NF-1:0] mask;
        int f, last;
        last = -1;
        for (int i = 0; i < NF; i++) mask[i] = trig | (|sv[8*i +: 8]);
        for (int i = 1; i <= NF; i++) begin
            f = (model_ptr + i) % NF;
            if (mask[f]) begin
                push_frame(f);
                last = f;
                if (count) exp_sent++;
            end
        end
        if (last >= 0) model_ptr = last;
        @(negedge clock);
        sync_i = sv; trigger_i = trig;
        @(negedge clock);
        sync_i = '0; trigger_i = 0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!(frames_sent_o == 16'(exp_sent) && !busy_o) && c < budget) begin
            @(negedge clock); #3; c++;
        end
        check("frames_sent", frames_sent_o, 16'(exp_sent));
        check("idle_after", busy_o, 0);
        check("queue_drained", exp_bytes.size(), 0);
    endtask

    task automatic rand_frame(input int f);
        for (int w = 0; w < 8; w++) mem[f][32*w +: 32] = $urandom;
    endtask

    initial begin
        int k;
        logic [NS-1:0] sv;
        logic [NF-1:0] m;
        logic tr;
        bit wren_seen;
        reset_n = 0; sync_i = '0; trigger_i = 0; clear_i = 0;
        for (int f = 0; f < NF; f++) rand_frame(f);
        repeat (3) @(negedge clock);
        #2;
        check("rst_busy", busy_o, 0);
        check("rst_wren", wren_o, 0);
        check("rst_byte", byte_o, 0);
        check("rst_sent", frames_sent_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_sel", frame_sel_o, 0);
        @(negedge clock);
        reset_n = 1;
        repeat (2) @(negedge clock);

        // Single frame via sensor 3, latency and gap timing.
        mem[0][31:0] = 32'h11223344;
        issue(24'h000008, 0, 1);
        repeat (2) @(negedge clock);
        #2; check("latency_wren_early", wren_o, 0);
        @(negedge clock);
        #2; check("latency_wren_on", wren_o, 1);
        k = 0;
        while (!(ss_n_i && exp_bytes.size() == 0) && k < 2000) begin
            @(negedge clock); #3; k++;
        end
        check("ss_rise_seen", ss_n_i, 1);
        k = 0;
        while (busy_o && k < 200) begin @(negedge clock); #3; k++; end
        check("gap_len", k, GAP + 1);
        check("sent_one", frames_sent_o, 1);

        // Two frames in the same cycle, pointer at 0: frame 1 then frame 2.
        issue(24'h020200, 0, 1);
        wait_done(3000);

        // Randomized sync subsets and triggers.
        for (int it = 0; it < 12; it++) begin
            m  = 3'($urandom_range(1, 7));
            tr = ($urandom_range(0, 4) == 0);
            sv = '0;
            for (int f = 0; f < NF; f++) begin
                if (tr || m[f]) rand_frame(f);
                if (m[f]) sv[8*f + $urandom_range(0, 7)] = 1'b1;
            end
            issue(sv, tr, 1);
            wait_done(4000);
        end
        check("no_overrun_yet", overrun_o, 0);

        // Shadow copy: frame data changes mid-frame must not leak out.
        mem[0] = '0;
        issue(24'h000001, 0, 1);
        k = 0;
        while (mon_idx != 10 && k < 2000) begin @(negedge clock); #3; k++; end
        check("reached_byte10", mon_idx, 10);
        mem[0] = '1;
        wait_done(3000);
        rand_frame(0);

        // Double sync before LATCH: overrun, frame sent once.
        issue(24'h000001, 0, 1);
        sync_i[0] = 1'b1;
        @(negedge clock);
        sync_i = '0;
        wait_done(3000);
        check("overrun_set", overrun_o, 1);
        @(negedge clock); clear_i = 1;
        @(negedge clock); clear_i = 0;
        #2; check("overrun_cleared", overrun_o, 0);

        // Sync on the LATCH cycle re-arms the frame without an overrun.
        issue(24'h000001, 0, 1);
        @(negedge clock);
        @(negedge clock);
        sync_i[0] = 1'b1;
        @(negedge clock);
        sync_i = '0;
        push_frame(0);
        exp_sent++;
        wait_done(5000);
        check("latch_sync_no_overrun", overrun_o, 0);

        // ss_n never rises: timeout after TO cycles in WAIT_END.
        hold_ss = 1;
        issue(24'h000100, 0, 0);
        k = 0;
        while (exp_bytes.size() != 0 && k < 2000) begin @(negedge clock); #3; k++; end
        k = 0;
        while (!timeout_o && k < 400) begin @(negedge clock); #3; k++; end
        check("timeout_delay", k, TO + 1);
        check("timeout_set", timeout_o, 1);
        check("timeout_no_count", frames_sent_o, 16'(exp_sent));
        k = 0;
        while (busy_o && k < 200) begin @(negedge clock); #3; k++; end
        check("timeout_to_idle", busy_o, 0);
        hold_ss = 0;
        repeat (5) @(negedge clock);
        clear_i = 1;
        @(negedge clock); clear_i = 0;
        #2; check("timeout_cleared", timeout_o, 0);

        // Reset during WAIT_ACK of byte 5.
        issue(24'h010000, 0, 0);
        k = 0;
        while (!(spi_st == 1 && spi_nbytes == 5) && k < 2000) begin @(negedge clock); #3; k++; end
        @(posedge clock); #1;
        check("pre_reset_wren", wren_o, 1);
        reset_n = 0;
        #1;
        check("mid_rst_wren", wren_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_sent", frames_sent_o, 0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        exp_bytes.delete(); exp_frame.delete();
        mon_idx = 0; exp_sent = 0; model_ptr = 0;
        wren_seen = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clock); #2;
            if (wren_o) wren_seen = 1;
        end
        check("post_rst_silent", wren_seen, 0);
        check("post_rst_idle", busy_o, 0);

        // Normal operation resumes after a fresh sync.
        issue(24'h000020, 0, 1);
        wait_done(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/darkroom_spi_scheduler.md
Name: darkroom_spi_scheduler

Overview:
Sequences decoded lighthouse sensor frames (256 bits, 8 sensors × 32 bits) into the byte-wide SPI master toward the ESP8266. It keeps one pending flag per frame, set by sensor sync pulses or a manual trigger, and picks frames round-robin. Each picked frame is latched into a shadow register and streamed over the SPI master's di_req/wren/wr_ack handshake. A programmable inter-frame gap follows each frame. It sits between the sensor decoder array and the spi_master instance, replacing ad-hoc frame muxing.

Parameters:
NUMBER_OF_SENSORS, 8, sensor count; NUM_FRAMES = ceil(NUMBER_OF_SENSORS/8), derived localparam, max 16
GAP_CYCLES, 1023, idle clocks after ss_n rises before the next frame may start (≥1)
TIMEOUT_CYCLES, 65535, max clocks in WAIT_END before abort

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sync_i  in  NUMBER_OF_SENSORS  per-sensor one-cycle pulse: non-skipping sweep decoded
trigger_i  in  1  debug: mark all frames pending
clear_i  in  1  clears sticky overrun_o/timeout_o
frame_sel_o  out  4  index of the frame whose data is requested
frame_i  in  256  sensor data of frame frame_sel_o (combinational from owner)
byte_o  out  8  byte to SPI master di_i
wren_o  out  1  SPI master write enable
di_req_i  in  1  SPI master requests next byte
wr_ack_i  in  1  SPI master accepted byte (one-cycle pulse)
ss_n_i  in  1  SPI master slave select (low during frame)
busy_o  out  1  high in any state except IDLE
frames_sent_o  out  16  completed-frame counter, wraps 0xFFFF→0
overrun_o  out  1  sticky: sync hit an already-pending frame
timeout_o  out  1  sticky: WAIT_END timed out

Behaviour:
- Reset: all outputs 0, pending=0, rr pointer=0, state IDLE. Mid-frame reset aborts immediately with wren_o=0. No resumption: pending flags are lost.
- Pending: frame f is set when any sync_i[8f+7:8f] is high, or when trigger_i is high (all frames). Cleared on the LATCH cycle of f. A set and a clear in the same cycle: set wins (f stays pending).
- overrun_o is set when a sync targets a frame that is already pending and is not being cleared that cycle. It is cleared by clear_i. Set beats clear in the same cycle.
- States: IDLE, SELECT, LATCH, SEND, WAIT_ACK, WAIT_REQ, WAIT_END, GAP.
- IDLE: if any pending, frame_sel_o = first pending index strictly after rr pointer (wrapping). Go to SELECT.
- SELECT: one cycle for frame_i to settle. Go to LATCH.
- LATCH: shadow <= frame_i; clear pending[sel]; rr pointer <= sel; byte index k=0. Go to SEND.
- SEND: byte_o = shadow[8k+7:8k] (byte 0 = bits 7:0 first); wren_o=1. Go to WAIT_ACK.
- WAIT_ACK: hold wren_o and byte_o until wr_ack_i; then wren_o=0. If k=31, go to WAIT_END; else k++ and go to WAIT_REQ.
- WAIT_REQ: wait for di_req_i=1, then go to SEND. A di_req_i already high counts.
- WAIT_END: register previous ss_n_i. On a 0→1 edge, frames_sent_o++ and go to GAP. If TIMEOUT_CYCLES elapse without the edge, set timeout_o, no increment, go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Pending flags keep accumulating in every state.
- Latency: pending set → wren_o high = 3 clocks (IDLE→SELECT→LATCH→SEND) when starting from IDLE.
- Shadow copy guarantees frame_i changes during SEND do not corrupt the frame in flight.
- NUM_FRAMES=1: round-robin degenerates to always frame 0.

Decomposition:
- Shared package darkroom_pkg: FRAME_WIDTH=256, BYTES_PER_FRAME=32, SENSORS_PER_FRAME=8, MAX_FRAMES=16, state enum encoding.
- One sub-module, darkroom_rr_arbiter: NUM_FRAMES-wide request vector plus pointer in, one-hot grant plus index out, purely combinational.
- Pending/FSM/counters stay in the top.

Test Plan:
- Pulse sync_i[3] with frame_i[31:0]=0x11223344 → frame_sel_o=0; SPI bytes 0x44,0x33,0x22,0x11,... for 32 bytes; frames_sent_o=1; busy_o drops GAP_CYCLES+1 cycles after ss_n_i rises.
- NUMBER_OF_SENSORS=24; sync_i[9] and sync_i[17] in the same cycle with rr pointer=0 → frames sent in order 1 then 2; pending empty afterward; frames_sent_o=2.
- Change frame_i to all-ones during byte 10 of a frame that latched all-zeros → all 32 transmitted bytes are 0x00.
- sync_i[0] twice while frame 0 is pending (before LATCH) → overrun_o=1 and frame 0 is sent exactly once; sync_i[0] on the LATCH cycle → frame 0 is sent again after GAP.
- Hold ss_n_i low forever after byte 31 ack, TIMEOUT_CYCLES=100 → timeout_o=1 after 100 cycles; frames_sent_o unchanged; returns to IDLE; clear_i clears timeout_o.
- Assert reset_n=0 during WAIT_ACK of byte 5 → wren_o, busy_o and frames_sent_o are 0 immediately; after release, no transmission without a new sync.
